// File: rtl/game_timer_120s.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_120s
//  Description : Countdown game clock for the Morse game. Counts down from
//                START_SECONDS in 0.1 s steps on each HundredmsTimeOut tick,
//                gates the upstream tick chain, and flags time-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_timer_120s #(
  parameter int START_SECONDS = 120,
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       HundredmsTimeOut,
  output logic       timer_enable,
  output logic [3:0] sec_hundreds,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       time_up,
  output logic       time_up_pulse
);

  // Start value split into BCD digits once, at elaboration
  localparam logic [3:0] c_hund       = 4'(START_SECONDS / 100);
  localparam logic [3:0] c_tens       = 4'((START_SECONDS / 10) % 10);
  localparam logic [3:0] c_ones       = 4'(START_SECONDS % 10);
  localparam logic [3:0] c_tenths_max = 4'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_hund, r_tens, r_ones, r_tenths;
  logic [3:0] w_hund_nxt, w_tens_nxt, w_ones_nxt, w_tenths_nxt;
  logic       r_timer_enable, r_running, r_time_up, r_time_up_pulse;
  logic       w_pulse_nxt;
  logic       w_secs_zero;

  assign w_secs_zero = (r_hund == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

  // Next-state and next-count logic; start outranks pause and tick everywhere
  always_comb begin
    w_state_nxt  = r_state;
    w_hund_nxt   = r_hund;
    w_tens_nxt   = r_tens;
    w_ones_nxt   = r_ones;
    w_tenths_nxt = r_tenths;
    w_pulse_nxt  = 1'b0;

    if (start) begin
      w_state_nxt  = RUN;
      w_hund_nxt   = c_hund;
      w_tens_nxt   = c_tens;
      w_ones_nxt   = c_ones;
      w_tenths_nxt = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          // Waiting for start; ticks and pause have no effect
        end
        RUN: begin
          if (pause) begin
            // A tick coinciding with pause is dropped
            w_state_nxt = PAUSED;
          end else if (HundredmsTimeOut) begin
            if (r_tenths != 4'd0) begin
              w_tenths_nxt = r_tenths - 4'd1;
              if (w_secs_zero && (r_tenths == 4'd1)) begin
                w_state_nxt = DONE;
                w_pulse_nxt = 1'b1;
              end
            end else if (!w_secs_zero) begin
              // Borrow from the seconds field, BCD style
              w_tenths_nxt = c_tenths_max;
              if (r_ones != 4'd0) begin
                w_ones_nxt = r_ones - 4'd1;
              end else begin
                w_ones_nxt = 4'd9;
                if (r_tens != 4'd0) begin
                  w_tens_nxt = r_tens - 4'd1;
                end else begin
                  w_tens_nxt = 4'd9;
                  w_hund_nxt = r_hund - 4'd1;
                end
              end
            end else begin
              // Already at 000.0: never underflow, just finish
              w_state_nxt = DONE;
              w_pulse_nxt = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            w_state_nxt = RUN;
          end
        end
        DONE: begin
          // Holds 000.0 until a restart
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, digit and output registers; outputs derive from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_hund          <= c_hund;
      r_tens          <= c_tens;
      r_ones          <= c_ones;
      r_tenths        <= 4'd0;
      r_timer_enable  <= 1'b0;
      r_running       <= 1'b0;
      r_time_up       <= 1'b0;
      r_time_up_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_hund          <= w_hund_nxt;
      r_tens          <= w_tens_nxt;
      r_ones          <= w_ones_nxt;
      r_tenths        <= w_tenths_nxt;
      r_timer_enable  <= (w_state_nxt == RUN);
      r_running       <= (w_state_nxt == RUN);
      r_time_up       <= (w_state_nxt == DONE);
      r_time_up_pulse <= w_pulse_nxt;
    end
  end

  assign timer_enable  = r_timer_enable;
  assign running       = r_running;
  assign time_up       = r_time_up;
  assign time_up_pulse = r_time_up_pulse;
  assign sec_hundreds  = r_hund;
  assign sec_tens      = r_tens;
  assign sec_ones      = r_ones;
  assign tenths        = r_tenths;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_120s.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_timer_120s
//  Description : Directed self-checking bench for game_timer_120s using the
//                default 120 s / 10 ticks-per-second configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer_120s;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       HundredmsTimeOut;
  logic       timer_enable;
  logic [3:0] sec_hundreds, sec_tens, sec_ones, tenths;
  logic       running, time_up, time_up_pulse;
  logic [15:0] val;

  int n_checks = 0;
  int n_errors = 0;

  game_timer_120s #(
    .START_SECONDS(120),
    .TICKS_PER_SEC(10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .pause            (pause),
    .HundredmsTimeOut (HundredmsTimeOut),
    .timer_enable     (timer_enable),
    .sec_hundreds     (sec_hundreds),
    .sec_tens         (sec_tens),
    .sec_ones         (sec_ones),
    .tenths           (tenths),
    .running          (running),
    .time_up          (time_up),
    .time_up_pulse    (time_up_pulse)
  );

  // Displayed value packed as hex-readable BCD: 120.0 reads as 16'h1200
  assign val = {sec_hundreds, sec_tens, sec_ones, tenths};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n back-to-back ticks
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      HundredmsTimeOut = 1'b1;
      step();
    end
    HundredmsTimeOut = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; HundredmsTimeOut = 1'b0;

    // Reset then idle
    step(); step();
    chk("reset_val",   val,                    16'h1200);
    chk("reset_en",    {15'd0, timer_enable},  16'd0);
    chk("reset_run",   {15'd0, running},       16'd0);
    chk("reset_tu",    {15'd0, time_up},       16'd0);
    chk("reset_tup",   {15'd0, time_up_pulse}, 16'd0);
    rst = 1'b0;
    ticks(5);
    chk("idle_val",    val,                    16'h1200);
    chk("idle_en",     {15'd0, timer_enable},  16'd0);
    chk("idle_tu",     {15'd0, time_up},       16'd0);

    // Basic countdown
    start = 1'b1; step(); start = 1'b0;
    chk("start_val",   val,                    16'h1200);
    chk("start_en",    {15'd0, timer_enable},  16'd1);
    chk("start_run",   {15'd0, running},       16'd1);
    ticks(1);
    chk("tick1",       val,                    16'h1199);
    ticks(9);
    chk("tick10",      val,                    16'h1190);
    ticks(190);
    chk("tick200",     val,                    16'h1000);
    ticks(1);
    chk("tick201",     val,                    16'h0999);

    // Expiry after 1200 ticks from a fresh start
    start = 1'b1; step(); start = 1'b0;
    chk("restart_val", val,                    16'h1200);
    ticks(1199);
    chk("tick1199",    val,                    16'h0001);
    chk("tick1199_tu", {15'd0, time_up},       16'd0);
    chk("tick1199_en", {15'd0, timer_enable},  16'd1);
    ticks(1);
    chk("done_val",    val,                    16'h0000);
    chk("done_tu",     {15'd0, time_up},       16'd1);
    chk("done_tup",    {15'd0, time_up_pulse}, 16'd1);
    chk("done_en",     {15'd0, timer_enable},  16'd0);
    chk("done_run",    {15'd0, running},       16'd0);
    step();
    chk("tup_1cyc",    {15'd0, time_up_pulse}, 16'd0);
    chk("done_tu_hold",{15'd0, time_up},       16'd1);
    ticks(3);
    chk("done_nowrap", val,                    16'h0000);
    chk("done_tu_3",   {15'd0, time_up},       16'd1);
    chk("done_en_3",   {15'd0, timer_enable},  16'd0);

    // Restart from DONE clears time_up on the same edge
    start = 1'b1; step(); start = 1'b0;
    chk("redone_val",  val,                    16'h1200);
    chk("redone_tu",   {15'd0, time_up},       16'd0);
    chk("redone_run",  {15'd0, running},       16'd1);

    // Pause holds the value and drops the upstream enable
    ticks(15);
    chk("pre_pause",   val,                    16'h1185);
    pause = 1'b1;
    step();
    chk("pause_en",    {15'd0, timer_enable},  16'd0);
    chk("pause_run",   {15'd0, running},       16'd0);
    ticks(7);
    chk("pause_hold",  val,                    16'h1185);
    chk("pause_en7",   {15'd0, timer_enable},  16'd0);
    pause = 1'b0;
    step();
    chk("resume_en",   {15'd0, timer_enable},  16'd1);
    ticks(1);
    chk("resume_tick", val,                    16'h1184);

    // Start coincident with a tick at 050.3: reload wins, tick dropped
    start = 1'b1; step(); start = 1'b0;
    ticks(697);
    chk("at_050_3",    val,                    16'h0503);
    start = 1'b1; HundredmsTimeOut = 1'b1;
    step();
    start = 1'b0; HundredmsTimeOut = 1'b0;
    chk("simul_val",   val,                    16'h1200);
    chk("simul_run",   {15'd0, running},       16'd1);

    // Reset coincident with a tick at 077.7
    ticks(423);
    chk("at_077_7",    val,                    16'h0777);
    rst = 1'b1; HundredmsTimeOut = 1'b1;
    step();
    rst = 1'b0; HundredmsTimeOut = 1'b0;
    chk("rstmid_val",  val,                    16'h1200);
    chk("rstmid_en",   {15'd0, timer_enable},  16'd0);
    chk("rstmid_run",  {15'd0, running},       16'd0);
    ticks(2);
    chk("rstmid_idle", val,                    16'h1200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
